// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state type and key/display constants for the calculator sequencer
package calc_pkg;

    typedef enum logic [1:0] {
        S_IN_A = 2'd0,
        S_IN_B = 2'd1,
        S_ADD  = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] BLANK    = 4'hF;
    localparam logic [3:0] TAG_A    = 4'hA;
    localparam logic [3:0] TAG_B    = 4'hB;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational one-digit BCD adder, blank inputs count as zero
module bcd_digit_add
    import calc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [4:0] w_sum;
    logic [4:0] w_adj;

    always_comb begin
        w_a   = (a == BLANK) ? 4'd0 : a;
        w_b   = (b == BLANK) ? 4'd0 : b;
        w_sum = {1'b0, w_a} + {1'b0, w_b} + {4'd0, cin};
        w_adj = w_sum - 5'd10;
        if (w_sum > 5'd9) begin
            s    = w_adj[3:0];
            cout = 1'b1;
        end else begin
            s    = w_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - keypad operand entry, digit-serial BCD add and display word sequencing
module calc_seq_ctrl
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] disp_data,
    output logic        busy,
    output logic        done
);

    state_t     r_state;
    logic [3:0] r_a2, r_a1, r_a0;
    logic [3:0] r_b2, r_b1, r_b0;
    logic [3:0] r_r3, r_r2, r_r1, r_r0;
    logic [1:0] r_idx;
    logic       r_carry;
    logic       r_done;

    logic       w_digit;
    logic       w_star;
    logic       w_hash;
    logic       w_clear;
    logic       w_load_a0;
    logic [3:0] w_add_a;
    logic [3:0] w_add_b;
    logic [3:0] w_sum;
    logic       w_cout;
    logic       w_r3_blank;
    logic       w_r2_blank;
    logic       w_r1_blank;

    assign w_digit = key_valid && (key_code <= 4'd9);
    assign w_star  = key_valid && (key_code == KEY_STAR);
    assign w_hash  = key_valid && (key_code == KEY_HASH);

    // Clear-all covers reset, '*' anywhere, and any '#'/digit that leaves the result view.
    assign w_load_a0 = !rst && (r_state == S_SHOW) && w_digit;
    assign w_clear   = rst || w_star || ((r_state == S_SHOW) && (w_hash || w_digit));

    always_comb begin
        w_add_a = BLANK;
        w_add_b = BLANK;
        case (r_idx)
            2'd0: begin w_add_a = r_a0; w_add_b = r_b0; end
            2'd1: begin w_add_a = r_a1; w_add_b = r_b1; end
            2'd2: begin w_add_a = r_a2; w_add_b = r_b2; end
            default: begin w_add_a = BLANK; w_add_b = BLANK; end
        endcase
    end

    bcd_digit_add u_digit_add (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= S_IN_A;
            r_a2    <= BLANK;
            r_a1    <= BLANK;
            r_a0    <= w_load_a0 ? key_code : BLANK;
            r_b2    <= BLANK;
            r_b1    <= BLANK;
            r_b0    <= BLANK;
            r_r3    <= BLANK;
            r_r2    <= BLANK;
            r_r1    <= BLANK;
            r_r0    <= BLANK;
            r_idx   <= 2'd0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IN_A: begin
                    if (w_digit) begin
                        r_a2 <= r_a1;
                        r_a1 <= r_a0;
                        r_a0 <= key_code;
                    end else if (w_hash) begin
                        r_state <= S_IN_B;
                    end
                end
                S_IN_B: begin
                    if (w_digit) begin
                        r_b2 <= r_b1;
                        r_b1 <= r_b0;
                        r_b0 <= key_code;
                    end else if (w_hash) begin
                        r_state <= S_ADD;
                        r_idx   <= 2'd0;
                        r_carry <= 1'b0;
                    end
                end
                S_ADD: begin
                    case (r_idx)
                        2'd0:    r_r0 <= w_sum;
                        2'd1:    r_r1 <= w_sum;
                        default: r_r2 <= w_sum;
                    endcase
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd2) begin
                        r_r3    <= {3'b000, w_cout};
                        r_state <= S_SHOW;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_SHOW;
                end
            endcase
        end
    end

    // Leading-zero blanking cascades from the top digit; R0 always shows.
    always_comb begin
        w_r3_blank = (r_r3 == 4'd0);
        w_r2_blank = w_r3_blank && (r_r2 == 4'd0);
        w_r1_blank = w_r2_blank && (r_r1 == 4'd0);
        disp_data  = 16'hFFFF;
        case (r_state)
            S_IN_A: disp_data = {TAG_A, r_a2, r_a1, r_a0};
            S_IN_B: disp_data = {TAG_B, r_b2, r_b1, r_b0};
            S_ADD:  disp_data = 16'hFFFF;
            default: disp_data = {w_r3_blank ? BLANK : r_r3,
                                  w_r2_blank ? BLANK : r_r2,
                                  w_r1_blank ? BLANK : r_r1,
                                  r_r0};
        endcase
    end

    assign busy = (r_state == S_ADD);
    assign done = r_done;

endmodule
